// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes,
// data-memory wait stalls, halt drain sequence and perf counters.
module pipeline_hazard_ctrl #(
   parameter int CNT_W        = 32,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_halt,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             ex_branch_taken,
   input  logic             mem_stall,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             stage_freeze,
   output logic             halted,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   logic [1:0]       state_reg, state_next;
   logic [DW-1:0]    drain_cnt_reg, drain_cnt_next;
   logic             halted_reg;
   logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
   logic             stall_inc, flush_inc;
   logic             lu;

   // x0 is hardwired zero, so a load targeting it never creates a dependency
   assign lu = ex_mem_read && (ex_rd != 5'd0) &&
               ((ex_rd == id_rs1) || (ex_rd == id_rs2));

   always_comb begin
      pc_write       = 1'b1;
      if_id_write    = 1'b1;
      if_id_flush    = 1'b0;
      id_ex_flush    = 1'b0;
      stage_freeze   = 1'b0;
      state_next     = state_reg;
      drain_cnt_next = drain_cnt_reg;
      stall_inc      = 1'b0;
      flush_inc      = 1'b0;

      case (state_reg)
         ST_RUN: begin
            if (mem_stall) begin
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               stage_freeze = 1'b1;
               stall_inc    = 1'b1;
            end else if (ex_branch_taken) begin
               // Anything in IF/ID is wrong-path, including a hazard or halt
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               flush_inc   = 1'b1;
            end else if (lu) begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               id_ex_flush = 1'b1;
               stall_inc   = 1'b1;
            end else if (id_halt) begin
               pc_write       = 1'b0;
               if_id_write    = 1'b0;
               id_ex_flush    = 1'b1;
               drain_cnt_next = DW'(DRAIN_CYCLES);
               state_next     = (DRAIN_CYCLES == 0) ? ST_HALTED : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            if (mem_stall) begin
               stage_freeze = 1'b1;
            end else begin
               drain_cnt_next = drain_cnt_reg - DW'(1);
               if (drain_cnt_reg <= DW'(1)) state_next = ST_HALTED;
            end
         end
         ST_HALTED: begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
            stage_freeze = 1'b1;
         end
         default: state_next = ST_RUN;
      endcase

      // Hold fetch and keep bubbles flowing until reset is released
      if (reset) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         stage_freeze = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= ST_RUN;
         drain_cnt_reg <= '0;
         halted_reg    <= 1'b0;
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         drain_cnt_reg <= drain_cnt_next;
         halted_reg    <= (state_next == ST_HALTED);
         if (stall_inc && !(&stall_cnt_reg)) stall_cnt_reg <= stall_cnt_reg + 1'b1;
         if (flush_inc && !(&flush_cnt_reg)) flush_cnt_reg <= flush_cnt_reg + 1'b1;
      end
   end

   assign halted      = halted_reg;
   assign stall_count = stall_cnt_reg;
   assign flush_count = flush_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a queue-based scoreboard;
// counters are 4 bits wide so saturation is reachable quickly.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_halt, ex_mem_read, ex_branch_taken, mem_stall;
   logic       pc_write, if_id_write, if_id_flush, id_ex_flush, stage_freeze, halted;
   logic [3:0] stall_count, flush_count;

   typedef struct {
      string       tag;
      logic [13:0] val;
   } exp_t;

   exp_t q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.CNT_W(4), .DRAIN_CYCLES(2)) dut (
      .clk             (clk),
      .reset           (reset),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_halt         (id_halt),
      .ex_mem_read     (ex_mem_read),
      .ex_rd           (ex_rd),
      .ex_branch_taken (ex_branch_taken),
      .mem_stall       (mem_stall),
      .pc_write        (pc_write),
      .if_id_write     (if_id_write),
      .if_id_flush     (if_id_flush),
      .id_ex_flush     (id_ex_flush),
      .stage_freeze    (stage_freeze),
      .halted          (halted),
      .stall_count     (stall_count),
      .flush_count     (flush_count)
   );

   task automatic check();
      exp_t        e;
      logic [13:0] obs;
      obs = {pc_write, if_id_write, if_id_flush, id_ex_flush, stage_freeze, halted,
             stall_count, flush_count};
      vectors++;
      if (q.size() == 0) begin
         miscompares++;
         $display("FAIL scoreboard_empty observed=%h expected=none", obs);
      end else begin
         e = q.pop_front();
         $display("[%0t] %-12s pcw/ifw/iff/idf/frz/hlt/sc/fc=%b_%h_%h exp=%b_%h_%h",
                  $time, e.tag, obs[13:8], obs[7:4], obs[3:0],
                  e.val[13:8], e.val[7:4], e.val[3:0]);
         assert (obs === e.val) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.val);
         end
      end
   endtask

   // Drive one cycle of inputs at the falling edge, push the expectation,
   // sample 2 time units later (well before the next rising edge).
   task automatic step(input string tag, input logic rst,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic hlt_in,
                       input logic mr, input logic [4:0] rd, input logic bt, input logic ms,
                       input logic [5:0] exp_ctl, input logic [3:0] exp_sc,
                       input logic [3:0] exp_fc);
      exp_t e;
      reset = rst; id_rs1 = rs1; id_rs2 = rs2; id_halt = hlt_in;
      ex_mem_read = mr; ex_rd = rd; ex_branch_taken = bt; mem_stall = ms;
      e.tag = tag;
      e.val = {exp_ctl, exp_sc, exp_fc};
      q.push_back(e);
      #2;
      check();
      @(negedge clk);
   endtask

   // Control expectation bundles: {pc_write, if_id_write, if_id_flush, id_ex_flush, stage_freeze, halted}
   localparam logic [5:0] C_RST  = 6'b001100;
   localparam logic [5:0] C_RUN  = 6'b110000;
   localparam logic [5:0] C_LU   = 6'b000100;
   localparam logic [5:0] C_BR   = 6'b111100;
   localparam logic [5:0] C_MS   = 6'b000010;
   localparam logic [5:0] C_DRN  = 6'b000100;
   localparam logic [5:0] C_DRNS = 6'b000110;
   localparam logic [5:0] C_HLT  = 6'b000111;

   initial begin
      reset = 1'b1; id_rs1 = '0; id_rs2 = '0; id_halt = 1'b0;
      ex_mem_read = 1'b0; ex_rd = '0; ex_branch_taken = 1'b0; mem_stall = 1'b0;
      @(negedge clk);

      step("reset",      1, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0);
      step("idle",       0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0);
      step("lu_rs1",     0, 5, 1, 0, 1, 5, 0, 0, C_LU,  0, 0);
      step("lu_after",   0, 5, 1, 0, 0, 0, 0, 0, C_RUN, 1, 0);
      step("x0_exempt",  0, 0, 0, 0, 1, 0, 0, 0, C_RUN, 1, 0);
      step("lu_rs2",     0, 1, 7, 1, 1, 7, 0, 0, C_LU,  1, 0);
      step("br_over",    0, 3, 0, 1, 1, 3, 1, 0, C_BR,  2, 0);
      step("br_after",   0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2, 1);
      step("mstall_pri", 0, 3, 0, 1, 1, 3, 1, 1, C_MS,  2, 1);
      step("halt_T",     0, 0, 0, 1, 0, 0, 0, 0, C_LU,  3, 1);
      step("drain_T1",   0, 0, 0, 1, 0, 0, 1, 0, C_DRN, 3, 1);
      step("drain_T2",   0, 0, 0, 0, 0, 0, 0, 0, C_DRN, 3, 1);
      for (int i = 0; i < 20; i++)
         step("halted_hold", 0, 4'(i), 0, 1, 1, 0, i[0], i[1], C_HLT, 3, 1);
      step("rst_async1", 1, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0);

      step("halt2_T",    0, 0, 0, 1, 0, 0, 0, 0, C_LU,   0, 0);
      step("drain_stall",0, 0, 0, 0, 0, 0, 0, 1, C_DRNS, 0, 0);
      step("drain2_T2",  0, 0, 0, 0, 0, 0, 0, 0, C_DRN,  0, 0);
      step("drain2_T3",  0, 0, 0, 0, 0, 0, 0, 0, C_DRN,  0, 0);
      step("halted_T4",  0, 0, 0, 0, 0, 0, 0, 0, C_HLT,  0, 0);
      step("rst_async2", 1, 0, 0, 0, 0, 0, 0, 0, C_RST,  0, 0);

      for (int i = 0; i < 20; i++)
         step("sat_stall", 0, 0, 0, 0, 0, 0, 0, 1, C_MS, (i > 15) ? 4'd15 : 4'(i), 0);
      step("sat_value",  0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 15, 0);
      step("rst_async3", 1, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0);
      step("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
